// File: rtl/pdm_rx_core.sv
// pdm_rx_core: PDM microphone receiver. Generates the microphone clock, synchronizes and samples
// the 1-bit stream, decimates it with a 3rd-order CIC (R=64, M=1) and queues 16-bit PCM samples
// in a small FIFO read through a 4-register slot interface.
module pdm_rx_core #(
   parameter int unsigned FIFO_AW = 4,
   parameter logic [7:0]  DIV_RST = 8'h13
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cs,
   input  logic        read,
   input  logic        write,
   input  logic [4:0]  addr,
   input  logic [31:0] wr_data,
   output logic [31:0] rd_data,
   output logic        pdm_clk,
   input  logic        pdm_in
);

   localparam int unsigned      Depth  = 1 << FIFO_AW;
   localparam logic [FIFO_AW:0] DepthC = (FIFO_AW + 1)'(Depth);

   // slot decode
   logic ctrl_wr, div_wr, pop_req, clear;

   // clock generator
   logic       enable_q, enable_d;
   logic [7:0] clk_div_q, clk_div_d;
   logic [7:0] div_cnt_q, div_cnt_d;
   logic       pdm_clk_q, pdm_clk_d;
   logic       samp;

   // synchronizer and CIC
   logic [1:0]  sync_q, sync_d;
   logic [18:0] integ1_q, integ1_d, integ2_q, integ2_d, integ3_q, integ3_d;
   logic [18:0] i3_dly_q, i3_dly_d, c1_dly_q, c1_dly_d, c2_dly_q, c2_dly_d;
   logic [18:0] xin, integ1_n, integ2_n, integ3_n, comb1, comb2, comb3;
   logic signed [19:0] comb_full, comb_shr;
   logic [15:0] pcm_sat;
   logic [5:0]  smp_cnt_q, smp_cnt_d;
   logic [1:0]  settle_q, settle_d;
   logic [15:0] pcm_q, pcm_d;
   logic        push_q, push_d;

   // FIFO
   logic [15:0]        mem_q [Depth];
   logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [FIFO_AW:0]   count_q, count_d;
   logic               ovf_q, ovf_d;
   logic               empty, full, pop, push_ok;
   logic [15:0]        head;

   logic unused_bits;
   assign unused_bits = ^{wr_data[31:8], addr[4:2]};

   assign pdm_clk = pdm_clk_q;

   // Slot decode, control registers and the PDM clock divider.
   always_comb begin
      ctrl_wr   = cs & write & (addr[1:0] == 2'd2);
      div_wr    = cs & write & (addr[1:0] == 2'd3);
      pop_req   = cs & read & (addr[1:0] == 2'd0);
      clear     = ctrl_wr & wr_data[1];
      enable_d  = ctrl_wr ? wr_data[0] : enable_q;
      clk_div_d = div_wr ? wr_data[7:0] : clk_div_q;
      div_cnt_d = div_cnt_q;
      pdm_clk_d = pdm_clk_q;
      samp      = 1'b0;
      if (!enable_d) begin
         // Disabling forces the mic clock low on the same edge.
         div_cnt_d = 8'd0;
         pdm_clk_d = 1'b0;
      end else if (div_wr) begin
         // New divisor: count restarts, next toggle uses the new value.
         div_cnt_d = 8'd0;
      end else if (div_cnt_q == clk_div_q) begin
         div_cnt_d = 8'd0;
         pdm_clk_d = ~pdm_clk_q;
         samp      = pdm_clk_q;
      end else begin
         div_cnt_d = div_cnt_q + 8'd1;
      end
   end

   // CIC integrators/combs, decimation counter, settling and PCM conversion.
   always_comb begin
      sync_d   = {sync_q[0], pdm_in};
      xin      = sync_q[1] ? 19'd1 : '1;
      integ1_n = integ1_q + xin;
      integ2_n = integ2_q + integ1_n;
      integ3_n = integ3_q + integ2_n;
      comb1    = integ3_n - i3_dly_q;
      comb2    = comb1 - c1_dly_q;
      comb3    = comb2 - c2_dly_q;
      // A 19-bit result cannot tell +2^18 from -2^18; only an all-same-sign window reaches
      // either, so the current input bit resolves it.
      comb_full = (comb3 == 19'h40000 && sync_q[1]) ? 20'sh40000 : signed'({comb3[18], comb3});
      comb_shr  = comb_full >>> 3;
      pcm_sat   = (comb_shr > 20'sd32767) ? 16'h7fff : comb_shr[15:0];

      integ1_d  = integ1_q;
      integ2_d  = integ2_q;
      integ3_d  = integ3_q;
      i3_dly_d  = i3_dly_q;
      c1_dly_d  = c1_dly_q;
      c2_dly_d  = c2_dly_q;
      smp_cnt_d = smp_cnt_q;
      settle_d  = settle_q;
      pcm_d     = pcm_q;
      push_d    = 1'b0;
      if (clear || !enable_d) begin
         integ1_d  = '0;
         integ2_d  = '0;
         integ3_d  = '0;
         i3_dly_d  = '0;
         c1_dly_d  = '0;
         c2_dly_d  = '0;
         smp_cnt_d = '0;
         settle_d  = '0;
      end else if (samp) begin
         integ1_d  = integ1_n;
         integ2_d  = integ2_n;
         integ3_d  = integ3_n;
         smp_cnt_d = smp_cnt_q + 6'd1;
         if (smp_cnt_q == 6'd63) begin
            i3_dly_d = integ3_n;
            c1_dly_d = comb1;
            c2_dly_d = comb2;
            if (settle_q == 2'd2) begin
               push_d = 1'b1;
               pcm_d  = pcm_sat;
            end else begin
               settle_d = settle_q + 2'd1;
            end
         end
      end
   end

   // FIFO pointers, occupancy and sticky overflow; clear wins over push and pop.
   always_comb begin
      empty    = (count_q == '0);
      full     = (count_q == DepthC);
      pop      = pop_req & ~empty;
      push_ok  = push_q & (~full | pop);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      if (clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         ovf_d    = 1'b0;
      end else begin
         if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
         count_d = count_q + (FIFO_AW + 1)'(push_ok) - (FIFO_AW + 1)'(pop);
         if (push_q && full && !pop) ovf_d = 1'b1;
      end
   end

   // Read mux; head reads zero while empty.
   always_comb begin
      head = empty ? 16'h0000 : mem_q[rd_ptr_q];
      unique case (addr[1:0])
         2'd0:    rd_data = {14'b0, ovf_q, empty, head};
         2'd1:    rd_data = {23'b0, 5'(count_q), full, empty, ovf_q, enable_q};
         default: rd_data = 32'h0;
      endcase
   end

   // Sample storage; contents are don't-care until written, so no reset.
   always_ff @(posedge clk) begin
      if (push_ok && !clear) mem_q[wr_ptr_q] <= pcm_q;
   end

   // State registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         enable_q  <= 1'b0;
         clk_div_q <= DIV_RST;
         div_cnt_q <= 8'd0;
         pdm_clk_q <= 1'b0;
         sync_q    <= 2'b00;
         integ1_q  <= '0;
         integ2_q  <= '0;
         integ3_q  <= '0;
         i3_dly_q  <= '0;
         c1_dly_q  <= '0;
         c2_dly_q  <= '0;
         smp_cnt_q <= '0;
         settle_q  <= '0;
         pcm_q     <= '0;
         push_q    <= 1'b0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         ovf_q     <= 1'b0;
      end else begin
         enable_q  <= enable_d;
         clk_div_q <= clk_div_d;
         div_cnt_q <= div_cnt_d;
         pdm_clk_q <= pdm_clk_d;
         sync_q    <= sync_d;
         integ1_q  <= integ1_d;
         integ2_q  <= integ2_d;
         integ3_q  <= integ3_d;
         i3_dly_q  <= i3_dly_d;
         c1_dly_q  <= c1_dly_d;
         c2_dly_q  <= c2_dly_d;
         smp_cnt_q <= smp_cnt_d;
         settle_q  <= settle_d;
         pcm_q     <= pcm_d;
         push_q    <= push_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         ovf_q     <= ovf_d;
      end
   end

endmodule

// File: tb/tb_pdm_rx_core.sv
// tb_pdm_rx_core: randomized bench for pdm_rx_core. A mic model drives a bit on each pdm_clk
// rise; the reference decimates the captured bits by direct convolution with the CIC impulse
// response and keeps an ideal 16-deep FIFO.
module tb_pdm_rx_core;

   logic        clk = 1'b0;
   logic        reset;
   logic        cs_t = 1'b0, cs_m = 1'b0, read_t = 1'b0, read_m = 1'b0;
   logic        cs, read, write;
   logic [4:0]  addr;
   logic [31:0] wr_data, rd_data;
   logic        pdm_clk, pdm_in;

   assign cs   = cs_t | cs_m;
   assign read = read_t | read_m;

   always #5 clk = ~clk;

   pdm_rx_core #(.FIFO_AW(4), .DIV_RST(8'h13)) dut (
      .clk(clk), .reset(reset), .cs(cs), .read(read), .write(write), .addr(addr),
      .wr_data(wr_data), .rd_data(rd_data), .pdm_clk(pdm_clk), .pdm_in(pdm_in)
   );

   int n_vec = 0;
   int n_bad = 0;
   int cyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // reference model state
   int          h[190];
   int          smp[$];
   logic [15:0] exp_q[$];
   logic        exp_ovf = 1'b0;
   int          dec_n = 0;
   logic        model_en = 1'b0;
   logic        pop_on_push = 1'b0;
   int          mode = 0;
   logic        alt = 1'b0;
   logic        pend = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   task automatic bus_wr(input logic [4:0] a, input logic [31:0] d);
      @(negedge clk); cs_t = 1'b1; write = 1'b1; addr = a; wr_data = d;
      @(negedge clk); cs_t = 1'b0; write = 1'b0; addr = 5'd0; wr_data = 32'h0;
   endtask

   task automatic bus_rd(input logic [4:0] a, output logic [31:0] d);
      @(negedge clk); cs_t = 1'b1; read_t = 1'b1; addr = a; #1 d = rd_data;
      @(negedge clk); cs_t = 1'b0; read_t = 1'b0; addr = 5'd0;
   endtask

   task automatic peek(input logic [4:0] a, output logic [31:0] d);
      @(negedge clk); addr = a; #1 d = rd_data; addr = 5'd0;
   endtask

   task automatic wait_pdm(input logic lvl, input string tag, output int t);
      int g = 0;
      while (pdm_clk !== lvl && g < 300) begin @(posedge clk); #1; g++; end
      if (pdm_clk !== lvl) check(tag, {31'b0, pdm_clk}, {31'b0, lvl});
      t = cyc;
   endtask

   task automatic wait_dec(input int n);
      int g = 0;
      int lim;
      lim = (n - dec_n) * 600 + 200;
      while (dec_n < n && g < lim) begin @(posedge clk); g++; end
      if (dec_n < n) check("wait_dec_timeout", dec_n, n);
      repeat (6) @(posedge clk);
   endtask

   task automatic start_run(input int m);
      model_en = 1'b0;
      bus_wr(5'd2, 32'h0);
      bus_wr(5'd2, 32'h2);
      exp_q.delete(); exp_ovf = 1'b0; smp.delete(); dec_n = 0;
      mode = m; alt = 1'b0;
      model_en = 1'b1;
      bus_wr(5'd2, 32'h1);
   endtask

   task automatic stop_run();
      model_en = 1'b0;
      bus_wr(5'd2, 32'h0);
   endtask

   task automatic drain(input string tag, input logic en);
      logic [31:0] d;
      int n;
      n = exp_q.size();
      peek(5'd1, d);
      check({tag, "_status"}, d, {23'b0, 5'(n), n == 16, n == 0, exp_ovf, en});
      for (int i = 0; i < n; i++) begin
         bus_rd(5'd0, d);
         check({tag, "_data"}, d, {14'b0, exp_ovf, 1'b0, exp_q.pop_front()});
      end
      peek(5'd0, d);
      check({tag, "_empty_head"}, d, {14'b0, exp_ovf, 1'b1, 16'h0000});
   endtask

   // Microphone: new data bit after every pdm_clk rise.
   initial begin
      forever begin
         @(posedge pdm_clk);
         case (mode)
            1:       pend = 1'b1;
            2:       pend = 1'b0;
            3:       begin alt = ~alt; pend = alt; end
            default: pend = 1'(($urandom % 2));
         endcase
         pdm_in = pend;
      end
   end

   // Reference: capture on each pdm_clk fall, decimate every 64 samples.
   initial begin
      int y, p, n;
      logic [15:0] v;
      forever begin
         @(negedge pdm_clk);
         if (model_en) begin
            smp.push_back(pend ? 1 : -1);
            n = smp.size();
            if (n % 64 == 0) begin
               y = 0;
               for (int k = 0; k < 190; k++) if (n - 1 - k >= 0) y += h[k] * smp[n - 1 - k];
               p = y >>> 3;
               if (p > 32767) p = 32767;
               if (p < -32768) p = -32768;
               v = p[15:0];
               dec_n++;
               if (dec_n > 2) begin
                  if (pop_on_push) begin
                     void'(exp_q.pop_front());
                     exp_q.push_back(v);
                     cs_m = 1'b1; read_m = 1'b1;
                     @(posedge clk); #1;
                     cs_m = 1'b0; read_m = 1'b0; pop_on_push = 1'b0;
                  end else if (exp_q.size() < 16) begin
                     exp_q.push_back(v);
                  end else begin
                     exp_ovf = 1'b1;
                  end
               end
            end
         end
      end
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] d;
      int t0, t1, t2;
      for (int k = 0; k < 190; k++) h[k] = 0;
      for (int a = 0; a < 64; a++)
         for (int b = 0; b < 64; b++)
            for (int c = 0; c < 64; c++) h[a + b + c]++;

      reset = 1'b0; write = 1'b0; addr = 5'd0; wr_data = 32'h0; pdm_in = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk); reset = 1'b1;

      // reset state
      peek(5'd1, d); check("rst_status", d, 32'h0000_0004);
      peek(5'd0, d); check("rst_head", d, 32'h0001_0000);
      peek(5'd2, d); check("rst_addr2", d, 32'h0);
      check("rst_pdm_clk", {31'b0, pdm_clk}, 32'h0);

      // default divider: 40-cycle period, 50% duty
      bus_wr(5'd2, 32'h1);
      wait_pdm(1'b0, "pdm_lo0", t0);
      wait_pdm(1'b1, "pdm_rise0", t0);
      wait_pdm(1'b0, "pdm_fall", t1);
      wait_pdm(1'b1, "pdm_rise1", t2);
      check("pdm_high_time", t1 - t0, 20);
      check("pdm_period", t2 - t0, 40);
      repeat (5) @(posedge clk);
      #1 check("pdm_hi_before_off", {31'b0, pdm_clk}, 32'h1);
      bus_wr(5'd2, 32'h0);
      check("pdm_off", {31'b0, pdm_clk}, 32'h0);

      // divider change
      bus_wr(5'd3, 32'h3);
      bus_wr(5'd2, 32'h1);
      wait_pdm(1'b1, "div3_rise0", t0);
      wait_pdm(1'b0, "div3_fall", t1);
      wait_pdm(1'b1, "div3_rise1", t2);
      check("div3_period", t2 - t0, 8);
      bus_wr(5'd2, 32'h0);

      // constant 1 -> full scale positive
      start_run(1); wait_dec(3); stop_run();
      peek(5'd0, d); check("const1_head", {16'h0, d[15:0]}, 32'h7fff);
      drain("const1", 1'b0);

      // constant 0 -> full scale negative
      start_run(2); wait_dec(3); stop_run();
      peek(5'd0, d); check("const0_head", {16'h0, d[15:0]}, 32'h8000);
      drain("const0", 1'b0);

      // alternating -> zero
      start_run(3); wait_dec(5); stop_run();
      drain("alt", 1'b0);

      // random stream
      start_run(0); wait_dec(7); stop_run();
      drain("rand", 1'b0);

      // overflow: 17 stored outputs, last dropped
      start_run(0); wait_dec(19); stop_run();
      drain("ovf", 1'b0);
      peek(5'd1, d); check("ovf_sticky", d, 32'h0000_0006);
      bus_wr(5'd2, 32'h2);
      peek(5'd1, d); check("clear_status", d, 32'h0000_0004);

      // pop on the push cycle while full
      start_run(0); wait_dec(18);
      pop_on_push = 1'b1;
      wait_dec(19);
      peek(5'd1, d); check("pop_push_status", d, {23'b0, 5'd16, 1'b1, 1'b0, 1'b0, 1'b1});
      stop_run();
      drain("pop_push", 1'b0);

      // asynchronous reset mid-stream, FIFO half full
      start_run(0); wait_dec(10);
      model_en = 1'b0;
      @(negedge clk); addr = 5'd1;
      #2 reset = 1'b0;
      #1 check("async_rst_status", rd_data, 32'h0000_0004);
      check("async_rst_pdm", {31'b0, pdm_clk}, 32'h0);
      addr = 5'd0;
      #1 check("async_rst_head", rd_data, 32'h0001_0000);
      repeat (2) @(posedge clk);
      @(negedge clk); reset = 1'b1;
      peek(5'd1, d); check("post_rst_status", d, 32'h0000_0004);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
